// File: rtl/pc_seq_pkg.sv
// Shared encodings for the program-counter sequencer and its return-address stack.
package pc_seq_pkg;

  typedef enum logic [1:0] {
    CMD_SEQ  = 2'd0,
    CMD_JUMP = 2'd1,
    CMD_CALL = 2'd2,
    CMD_RET  = 2'd3
  } cmd_e;

  typedef enum logic [1:0] {
    ERR_NONE      = 2'd0,
    ERR_MISALIGN  = 2'd1,
    ERR_RAS_UNDER = 2'd2
  } err_e;

  typedef enum logic [0:0] {
    StRun  = 1'b0,
    StHalt = 1'b1
  } state_e;

endpackage

// File: rtl/ras_stack.sv
// Circular return-address stack: a full push overwrites the oldest entry and
// raises a one-cycle overflow pulse instead of failing.
module ras_stack #(
  parameter int unsigned Width = 64,
  parameter int unsigned Depth = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] push_data,
  output logic [Width-1:0] pop_data,
  output logic             empty,
  output logic             full,
  output logic             overflow
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = $clog2(Depth + 1);

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  ptr_q, ptr_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic             ovf_q, ovf_d;

  assign empty    = (cnt_q == '0);
  assign full     = (cnt_q == CntW'(Depth));
  assign overflow = ovf_q;
  // Top of stack sits one below the write pointer; modulo wrap is free.
  assign pop_data = mem_q[ptr_q - PtrW'(1)];

  always_comb begin
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ovf_d = 1'b0;
    if (push) begin
      ptr_d = ptr_q + PtrW'(1);
      if (full) begin
        ovf_d = 1'b1;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end else if (pop && !empty) begin
      ptr_d = ptr_q - PtrW'(1);
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ptr_q <= '0;
      cnt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ovf_q <= ovf_d;
    end
  end

  // Entry contents need no reset.
  always_ff @(posedge clk) begin
    if (reset && push) begin
      mem_q[ptr_q] <= push_data;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch program counter with sequential/jump/call/return sequencing, stall,
// a return-address stack, and a halt-on-error state left only by reset.
module pc_sequencer
  import pc_seq_pkg::*;
#(
  parameter int unsigned       ADDR_W      = 64,
  parameter logic [ADDR_W-1:0] RESET_VEC   = '0,
  parameter int unsigned       INSTR_BYTES = 4,
  parameter int unsigned       RAS_DEPTH   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              stall,
  input  logic [1:0]        cmd,
  input  logic [ADDR_W-1:0] target,
  output logic [ADDR_W-1:0] pc_out,
  output logic [ADDR_W-1:0] pc_plus,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              ras_overflow,
  output logic              halted,
  output logic [1:0]        err_code
);

  localparam int unsigned AlignW = $clog2(INSTR_BYTES);

  logic [ADDR_W-1:0] pc_q, pc_d;
  state_e            state_q, state_d;
  err_e              err_q, err_d;
  logic              misaligned;
  logic              ras_push, ras_pop;
  logic [ADDR_W-1:0] ras_pop_data;

  assign pc_plus  = pc_q + ADDR_W'(INSTR_BYTES);
  assign pc_out   = pc_q;
  assign halted   = (state_q == StHalt);
  assign err_code = err_q;

  generate
    if (AlignW == 0) begin : g_no_align
      assign misaligned = 1'b0;
    end else begin : g_align
      assign misaligned = |target[AlignW-1:0];
    end
  endgenerate

  always_comb begin
    pc_d     = pc_q;
    state_d  = state_q;
    err_d    = err_q;
    ras_push = 1'b0;
    ras_pop  = 1'b0;
    if (state_q == StRun && !stall) begin
      unique case (cmd_e'(cmd))
        CMD_SEQ: begin
          pc_d = pc_plus;
        end
        CMD_JUMP: begin
          if (misaligned) begin
            err_d   = ERR_MISALIGN;
            state_d = StHalt;
          end else begin
            pc_d = target;
          end
        end
        CMD_CALL: begin
          if (misaligned) begin
            err_d   = ERR_MISALIGN;
            state_d = StHalt;
          end else begin
            ras_push = 1'b1;
            pc_d     = target;
          end
        end
        CMD_RET: begin
          if (ras_empty) begin
            err_d   = ERR_RAS_UNDER;
            state_d = StHalt;
          end else begin
            ras_pop = 1'b1;
            pc_d    = ras_pop_data;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      pc_q    <= RESET_VEC;
      state_q <= StRun;
      err_q   <= ERR_NONE;
    end else begin
      pc_q    <= pc_d;
      state_q <= state_d;
      err_q   <= err_d;
    end
  end

  ras_stack #(
    .Width(ADDR_W),
    .Depth(RAS_DEPTH)
  ) u_ras (
    .clk      (clk),
    .reset    (reset),
    .push     (ras_push),
    .pop      (ras_pop),
    .push_data(pc_plus),
    .pop_data (ras_pop_data),
    .empty    (ras_empty),
    .full     (ras_full),
    .overflow (ras_overflow)
  );

endmodule

// File: tb/tb_pc_sequencer.sv
// Scoreboard bench: the driver queues hand-computed expectations per cycle and
// a monitor compares them against both sequencer instances after each edge.
module tb_pc_sequencer;
  import pc_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        stall = 1'b0;
  logic [1:0]  cmd = CMD_SEQ;
  logic [63:0] target = '0;
  logic [63:0] pc_out, pc_plus;
  logic        ras_empty, ras_full, ras_overflow, halted;
  logic [1:0]  err_code;

  logic        w_reset = 1'b0;
  logic [15:0] w_pc_out, w_pc_plus;
  logic        w_empty, w_full, w_ovf, w_halted;
  logic [1:0]  w_err;

  logic        w_rst_v = 1'b0;
  logic [15:0] w_exp_v = 16'hFFFC;

  typedef struct {
    logic [63:0] pc;
    logic        halt;
    logic [1:0]  err;
    logic        empty;
    logic        full;
    logic        ovf;
    logic [15:0] wpc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .ADDR_W(64), .RESET_VEC(64'h1000), .INSTR_BYTES(4), .RAS_DEPTH(8)
  ) u_dut (
    .clk(clk), .reset(reset), .stall(stall), .cmd(cmd), .target(target),
    .pc_out(pc_out), .pc_plus(pc_plus), .ras_empty(ras_empty), .ras_full(ras_full),
    .ras_overflow(ras_overflow), .halted(halted), .err_code(err_code)
  );

  pc_sequencer #(
    .ADDR_W(16), .RESET_VEC(16'hFFFC), .INSTR_BYTES(4), .RAS_DEPTH(8)
  ) u_wrap (
    .clk(clk), .reset(w_reset), .stall(1'b0), .cmd(CMD_SEQ), .target(16'h0000),
    .pc_out(w_pc_out), .pc_plus(w_pc_plus), .ras_empty(w_empty), .ras_full(w_full),
    .ras_overflow(w_ovf), .halted(w_halted), .err_code(w_err)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one expectation per clock edge after inputs were driven.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_out", pc_out, e.pc);
        chk("pc_plus", pc_plus, e.pc + 64'd4);
        chk("halted", {63'b0, halted}, {63'b0, e.halt});
        chk("err_code", {62'b0, err_code}, {62'b0, e.err});
        chk("ras_empty", {63'b0, ras_empty}, {63'b0, e.empty});
        chk("ras_full", {63'b0, ras_full}, {63'b0, e.full});
        chk("ras_overflow", {63'b0, ras_overflow}, {63'b0, e.ovf});
        chk("wrap_pc", {48'b0, w_pc_out}, {48'b0, e.wpc});
        chk("wrap_halted", {63'b0, w_halted}, 64'd0);
      end
    end
  end

  task automatic step(input logic r, input logic s, input logic [1:0] c,
                      input logic [63:0] t, input logic [63:0] ep, input logic eh,
                      input logic [1:0] ee, input logic eem, input logic efu,
                      input logic eov);
    exp_t e;
    @(negedge clk);
    reset   = r;
    stall   = s;
    cmd     = c;
    target  = t;
    w_reset = w_rst_v;
    e.pc = ep; e.halt = eh; e.err = ee; e.empty = eem; e.full = efu; e.ovf = eov;
    e.wpc = w_exp_v;
    exp_q.push_back(e);
  endtask

  task automatic rst1();
    step(1'b0, 1'b0, CMD_SEQ, 64'h0, 64'h1000, 1'b0, ERR_NONE, 1'b1, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset and sequential fetch
    rst1(); rst1();
    step(1, 0, CMD_SEQ, 0, 64'h1004, 0, ERR_NONE, 1, 0, 0);
    step(1, 0, CMD_SEQ, 0, 64'h1008, 0, ERR_NONE, 1, 0, 0);
    step(1, 0, CMD_SEQ, 0, 64'h100C, 0, ERR_NONE, 1, 0, 0);

    // Stall ignores cmd
    rst1();
    step(1, 0, CMD_SEQ, 0, 64'h1004, 0, ERR_NONE, 1, 0, 0);
    step(1, 0, CMD_SEQ, 0, 64'h1008, 0, ERR_NONE, 1, 0, 0);
    for (int i = 0; i < 3; i++)
      step(1, 1, CMD_JUMP, 64'h2000, 64'h1008, 0, ERR_NONE, 1, 0, 0);
    step(1, 0, CMD_SEQ, 0, 64'h100C, 0, ERR_NONE, 1, 0, 0);
    // Reset wins over stall
    step(0, 1, CMD_JUMP, 64'h2000, 64'h1000, 0, ERR_NONE, 1, 0, 0);

    // Call/return
    step(1, 0, CMD_CALL, 64'h3000, 64'h3000, 0, ERR_NONE, 0, 0, 0);
    step(1, 0, CMD_CALL, 64'h4000, 64'h4000, 0, ERR_NONE, 0, 0, 0);
    step(1, 0, CMD_RET, 0, 64'h3004, 0, ERR_NONE, 0, 0, 0);
    step(1, 0, CMD_RET, 0, 64'h1004, 0, ERR_NONE, 1, 0, 0);

    // RAS overflow: 9 calls, oldest return address (0x1004) is lost
    rst1();
    for (int i = 0; i < 9; i++)
      step(1, 0, CMD_CALL, 64'h5000 + 64'(i) * 64'h100, 64'h5000 + 64'(i) * 64'h100,
           0, ERR_NONE, 0, (i >= 7), (i == 8));
    for (int k = 0; k < 8; k++)
      step(1, 0, CMD_RET, 0, 64'h5704 - 64'(k) * 64'h100, 0, ERR_NONE, (k == 7), 0, 0);
    step(1, 0, CMD_RET, 0, 64'h5004, 1, ERR_RAS_UNDER, 1, 0, 0);
    step(1, 0, CMD_SEQ, 0, 64'h5004, 1, ERR_RAS_UNDER, 1, 0, 0);
    rst1();

    // Misaligned jump halts and freezes
    step(1, 0, CMD_JUMP, 64'h2002, 64'h1000, 1, ERR_MISALIGN, 1, 0, 0);
    step(1, 0, CMD_JUMP, 64'h3000, 64'h1000, 1, ERR_MISALIGN, 1, 0, 0);
    step(1, 0, CMD_SEQ, 0, 64'h1000, 1, ERR_MISALIGN, 1, 0, 0);
    step(1, 1, CMD_RET, 0, 64'h1000, 1, ERR_MISALIGN, 1, 0, 0);
    // Reset during halt recovers
    rst1();

    // Misaligned call: no push
    step(1, 0, CMD_SEQ, 0, 64'h1004, 0, ERR_NONE, 1, 0, 0);
    step(1, 0, CMD_CALL, 64'h3001, 64'h1004, 1, ERR_MISALIGN, 1, 0, 0);
    rst1();

    // 16-bit instance wraps from 0xFFFC to 0x0000
    w_rst_v = 1'b1;
    w_exp_v = 16'h0000;
    step(1, 0, CMD_SEQ, 0, 64'h1004, 0, ERR_NONE, 1, 0, 0);
    w_exp_v = 16'h0004;
    step(1, 0, CMD_SEQ, 0, 64'h1008, 0, ERR_NONE, 1, 0, 0);

    begin
      int budget = 20;
      while (exp_q.size() > 0 && budget > 0) begin
        @(posedge clk);
        budget--;
      end
      #2;
      if (exp_q.size() > 0) begin
        checks++;
        errors++;
        $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
    end
    chk("wrap_err", {62'b0, w_err}, 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Parametrised program-counter sequencer for the sequential core, replacing the plain PC register at the head of instruction fetch. It holds the current fetch address and selects the next one from sequential, jump, call or return commands, honouring a stall input. A circular return-address stack (RAS) serves call/return. The block halts on a misaligned target or a return with an empty RAS.

Parameters:
ADDR_W, 64, PC and address width in bits
RESET_VEC, 0, PC value loaded on reset; must be INSTR_BYTES-aligned
INSTR_BYTES, 4, sequential increment; power of two, at least 1
RAS_DEPTH, 8, RAS entries; power of two, at least 2

Ports:
clk  in  1  core clock; all state updates on its rising edge
reset  in  1  synchronous, active-low reset
stall  in  1  1 = hold PC, RAS and FSM; cmd is ignored
cmd  in  2  0 SEQ, 1 JUMP, 2 CALL, 3 RET
target  in  ADDR_W  destination address for JUMP and CALL
pc_out  out  ADDR_W  current fetch address (registered)
pc_plus  out  ADDR_W  pc_out + INSTR_BYTES (combinational, wraps modulo 2^ADDR_W)
ras_empty  out  1  RAS count is 0
ras_full  out  1  RAS count is RAS_DEPTH
ras_overflow  out  1  one-cycle pulse: a CALL overwrote the oldest RAS entry
halted  out  1  FSM is in HALT
err_code  out  2  0 none, 1 misaligned target, 2 RAS underflow; sticky while halted

Behaviour:
- Reset: sampled on the rising clk edge when reset is 0.
  - Sets pc_out = RESET_VEC, RAS count = 0, RAS pointer = 0 (entry contents are don't-care).
  - Sets FSM = RUN, halted = 0, err_code = 0, ras_overflow = 0.
  - Reset has priority over every other input, including a reset asserted in the middle of a stall or HALT.
- FSM states: RUN and HALT.
  - RUN to HALT on an error (below).
  - HALT is left only by reset.
  - In HALT, pc_out, the RAS and err_code are frozen, and cmd and stall are ignored.
- RUN with stall = 1: nothing changes. ras_overflow = 0.
- RUN with stall = 0, single-cycle latency (next-cycle pc_out):
  - SEQ: pc_out <= pc_plus.
  - JUMP: if target is aligned, pc_out <= target.
  - CALL: if target is aligned, push pc_plus onto the RAS and set pc_out <= target.
  - RET: if the RAS is non-empty, pop and set pc_out <= popped value.
- Alignment: target is misaligned when target[log2(INSTR_BYTES)-1:0] != 0. With INSTR_BYTES = 1 there is no alignment check.
- Error on misaligned JUMP/CALL:
  - pc_out holds and there is no push.
  - err_code <= 1 and FSM goes to HALT.
- Error on RET with the RAS empty:
  - pc_out holds.
  - err_code <= 2 and FSM goes to HALT.
- RAS push when count < RAS_DEPTH:
  - Write at the pointer, increment the pointer modulo RAS_DEPTH, count++.
- RAS push when full:
  - Write at the pointer, which overwrites the oldest entry, then increment the pointer modulo RAS_DEPTH.
  - Count stays RAS_DEPTH.
  - ras_overflow = 1 for the following cycle. This is not an error and does not halt.
- RAS pop: decrement the pointer modulo RAS_DEPTH, read the entry at the new pointer, count--.
- PC arithmetic: pc_plus at the top address wraps to 0 silently.
- The RAS uses no read-during-write bypass. Push and pop never happen in the same cycle because cmd is single-valued.
- Outputs are registered except pc_plus, ras_empty and ras_full. The latter two are decoded from the count register.

Decomposition:
- Shared package pc_seq_pkg:
  - cmd encodings CMD_SEQ/JUMP/CALL/RET
  - err_code encodings ERR_NONE/MISALIGN/RAS_UNDER
  - FSM state encodings
- One sub-module, ras_stack: parametrised by width and depth, with push, pop, push_data, pop_data, empty, full and overflow outputs, and the circular pointer and count logic.
- The top level holds the PC register, next-PC mux, alignment check and FSM.

Test Plan:
- Reset and SEQ (RESET_VEC=0x1000): hold reset low 2 cycles, release, then 3 SEQ -> pc_out 0x1000, 0x1004, 0x1008, 0x100C.
- Stall: from 0x1008, stall 3 cycles while cmd = JUMP 0x2000, then stall = 0 with SEQ -> pc_out holds 0x1008 for 3 cycles, then 0x100C.
- Call/return:
  - At 0x1000: CALL 0x3000, then CALL 0x4000, then RET, then RET.
  - Required pc_out: 0x3000, 0x4000, 0x3004, 0x1004.
  - ras_empty = 1 at the end.
- RAS overflow (RAS_DEPTH=8):
  - Issue 9 CALLs at distinct PCs.
  - ras_overflow pulses exactly once, on the cycle after the 9th.
  - 8 RETs then return the 8 newest return addresses in LIFO order.
  - A 9th RET gives halted = 1, err_code = 2.
- Misalignment: JUMP 0x2002 -> pc_out unchanged, halted = 1, err_code = 1. Further JUMP/SEQ commands leave pc_out frozen.
- Recovery from HALT: assert reset for 1 cycle -> pc_out = RESET_VEC, halted = 0, err_code = 0, ras_empty = 1.
- Wrap-around (ADDR_W=16, RESET_VEC=0xFFFC): one SEQ -> pc_out = 0x0000, no error.
